// File: rtl/multi_channel_freq_controller.sv
// -----------------------------------------------------------------------------
// multi_channel_freq_controller
//
// Purpose:
//   Push-button frequency setter for NUM_CH independent channels. Four raw
//   active-low keys (up, down, scale, chan) are synchronised, debounced and
//   turned into one-cycle action pulses by a small per-key FSM. Up/down move
//   the selected channel by 10^scale with saturation at 0 and
//   FREQUENCY_RANGE-1; scale cycles the step exponent; chan cycles the
//   selected channel.
//
// Configuration macro:
//   FREQ_CTRL_AUTO_REPEAT_EN - when defined, holding up/down auto-repeats
//   (first repeat after REPEAT_DELAY cycles, then every REPEAT_PERIOD cycles).
//   When undefined, each press yields exactly one action.
//
// Ports:
//   clk           in   single clock
//   reset         in   synchronous, active-high
//   key_up_n      in   raw push-button, active-low, asynchronous
//   key_down_n    in   raw push-button, active-low, asynchronous
//   key_scale_n   in   raw push-button, active-low, asynchronous
//   key_chan_n    in   raw push-button, active-low, asynchronous
//   frequency_out out  NUM_CH*W, channel k at [k*W+W-1 : k*W]
//   sel_freq      out  W, registered frequency of the selected channel
//   sel_chan      out  selected channel index
//   scale_out     out  2, step exponent (step = 1/10/100/1000)
//   update_pulse  out  one-cycle strobe on any frequency/channel/scale change
// -----------------------------------------------------------------------------
module multi_channel_freq_controller #(
  parameter int NUM_CH          = 2,
  parameter int W               = 13,
  parameter int FREQUENCY_RANGE = 8192,
  parameter int DEFAULT_FREQ    = 1000,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic                                            clk,
  input  logic                                            reset,
  input  logic                                            key_up_n,
  input  logic                                            key_down_n,
  input  logic                                            key_scale_n,
  input  logic                                            key_chan_n,
  output logic [NUM_CH*W-1:0]                             frequency_out,
  output logic [W-1:0]                                    sel_freq,
  output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] sel_chan,
  output logic [1:0]                                      scale_out,
  output logic                                            update_pulse
);

  localparam int SW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  // Arithmetic width: one carry bit above W, but never narrower than the
  // largest step (1000) so the step constant is never truncated.
  localparam int AW  = (W + 1 > 11) ? W + 1 : 11;

  localparam logic [W-1:0] MAX_F = W'(FREQUENCY_RANGE - 1);

  // Key indices
  localparam int K_UP    = 0;
  localparam int K_DOWN  = 1;
  localparam int K_SCALE = 2;
  localparam int K_CHAN  = 3;

  if (NUM_CH < 1 || NUM_CH > 8 || FREQUENCY_RANGE > 2**W ||
      DEFAULT_FREQ >= FREQUENCY_RANGE || DEBOUNCE_CYCLES < 1 ||
      REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
    $error("multi_channel_freq_controller: illegal parameter combination");
  end

`ifdef FREQ_CTRL_AUTO_REPEAT_EN
  typedef enum logic [1:0] {ST_IDLE, ST_HELD, ST_REPEAT} key_state_t;
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TW   = $clog2(RMAX + 1);
`else
  typedef enum logic {ST_IDLE, ST_HELD} key_state_t;
`endif

  logic [3:0] w_raw;
  logic [3:0] w_act;

  assign w_raw = {key_chan_n, key_scale_n, key_down_n, key_up_n};

  // ---------------------------------------------------------------------------
  // Per-key synchroniser, debouncer and press/repeat FSM
  // ---------------------------------------------------------------------------
  for (genvar k = 0; k < 4; k++) begin : g_key
    localparam bit CAN_REPEAT = (k == K_UP) || (k == K_DOWN);

    logic             r_s1;
    logic             r_s2;
    logic             r_level;   // debounced level, 1 = released
    logic [DBW-1:0]   r_cnt;
    key_state_t       r_state;
    key_state_t       w_state_nx;
    logic             r_act;
    logic             w_act_nx;
`ifdef FREQ_CTRL_AUTO_REPEAT_EN
    logic [TW-1:0]    r_timer;
    logic [TW-1:0]    w_timer_nx;
`endif

    // Counter restarts whenever the synchronised sample agrees with the
    // debounced level, so only an unbroken run of differing samples flips it.
    always_ff @(posedge clk) begin
      if (reset) begin
        r_s1    <= 1'b1;
        r_s2    <= 1'b1;
        r_level <= 1'b1;
        r_cnt   <= '0;
      end else begin
        r_s1 <= w_raw[k];
        r_s2 <= r_s1;
        if (r_s2 == r_level) begin
          r_cnt <= '0;
        end else if (r_cnt == DBW'(DEBOUNCE_CYCLES - 1)) begin
          r_level <= r_s2;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        r_state <= ST_IDLE;
        r_act   <= 1'b0;
`ifdef FREQ_CTRL_AUTO_REPEAT_EN
        r_timer <= '0;
`endif
      end else begin
        r_state <= w_state_nx;
        r_act   <= w_act_nx;
`ifdef FREQ_CTRL_AUTO_REPEAT_EN
        r_timer <= w_timer_nx;
`endif
      end
    end

    always_comb begin
      w_state_nx = r_state;
      w_act_nx   = 1'b0;
`ifdef FREQ_CTRL_AUTO_REPEAT_EN
      w_timer_nx = r_timer;
`endif
      case (r_state)
        ST_IDLE: begin
          if (!r_level) begin
            w_state_nx = ST_HELD;
            w_act_nx   = 1'b1;
`ifdef FREQ_CTRL_AUTO_REPEAT_EN
            w_timer_nx = '0;
`endif
          end
        end
        ST_HELD: begin
          if (r_level) begin
            w_state_nx = ST_IDLE;
          end
`ifdef FREQ_CTRL_AUTO_REPEAT_EN
          else if (CAN_REPEAT) begin
            if (r_timer == TW'(REPEAT_DELAY - 1)) begin
              w_state_nx = ST_REPEAT;
              w_act_nx   = 1'b1;
              w_timer_nx = '0;
            end else begin
              w_timer_nx = r_timer + 1'b1;
            end
          end
`endif
        end
`ifdef FREQ_CTRL_AUTO_REPEAT_EN
        ST_REPEAT: begin
          if (r_level) begin
            w_state_nx = ST_IDLE;
          end else if (r_timer == TW'(REPEAT_PERIOD - 1)) begin
            w_act_nx   = 1'b1;
            w_timer_nx = '0;
          end else begin
            w_timer_nx = r_timer + 1'b1;
          end
        end
`endif
        default: w_state_nx = ST_IDLE;
      endcase
    end

    assign w_act[k] = r_act;
  end

  // ---------------------------------------------------------------------------
  // Frequency / channel / scale datapath
  // ---------------------------------------------------------------------------
  logic [W-1:0]  r_freq [NUM_CH];
  logic [SW-1:0] r_sel;
  logic [1:0]    r_scale;
  logic          r_upd;
  logic [W-1:0]  r_sel_freq;

  logic [W-1:0]  w_cur;
  logic [AW-1:0] w_step;
  logic [AW-1:0] w_sum;
  logic [W-1:0]  w_up_val;
  logic [W-1:0]  w_down_val;
  logic [W-1:0]  w_freq_nx;
  logic          w_freq_we;
  logic [SW-1:0] w_sel_nx;
  logic [1:0]    w_scale_nx;
  logic          w_upd;

  assign w_cur = r_freq[r_sel];

  always_comb begin
    case (r_scale)
      2'd0:    w_step = AW'(1);
      2'd1:    w_step = AW'(10);
      2'd2:    w_step = AW'(100);
      default: w_step = AW'(1000);
    endcase
  end

  always_comb begin
    w_sum      = AW'(w_cur) + w_step;
    w_up_val   = (w_sum > AW'(MAX_F)) ? MAX_F : w_sum[W-1:0];
    w_down_val = (AW'(w_cur) < w_step) ? '0 : w_cur - w_step[W-1:0];
  end

  // Only the highest-priority action of a cycle is applied; up and down
  // together cancel. Saturated no-op moves do not strobe update_pulse.
  always_comb begin
    w_freq_nx  = w_cur;
    w_freq_we  = 1'b0;
    w_sel_nx   = r_sel;
    w_scale_nx = r_scale;
    w_upd      = 1'b0;
    if (w_act[K_CHAN]) begin
      if (NUM_CH > 1) begin
        w_sel_nx = (r_sel == SW'(NUM_CH - 1)) ? '0 : r_sel + 1'b1;
        w_upd    = 1'b1;
      end
    end else if (w_act[K_SCALE]) begin
      w_scale_nx = r_scale + 2'd1;
      w_upd      = 1'b1;
    end else if (w_act[K_UP] && !w_act[K_DOWN]) begin
      if (w_cur != MAX_F) begin
        w_freq_nx = w_up_val;
        w_freq_we = 1'b1;
        w_upd     = 1'b1;
      end
    end else if (w_act[K_DOWN] && !w_act[K_UP]) begin
      if (w_cur != '0) begin
        w_freq_nx = w_down_val;
        w_freq_we = 1'b1;
        w_upd     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        r_freq[i] <= W'(DEFAULT_FREQ);
      end
      r_sel      <= '0;
      r_scale    <= '0;
      r_upd      <= 1'b0;
      r_sel_freq <= W'(DEFAULT_FREQ);
    end else begin
      if (w_freq_we) begin
        r_freq[r_sel] <= w_freq_nx;
      end
      r_sel      <= w_sel_nx;
      r_scale    <= w_scale_nx;
      r_upd      <= w_upd;
      // Track the value the selected channel will hold after this edge so
      // sel_freq always agrees with frequency_out and sel_chan.
      r_sel_freq <= w_freq_we ? w_freq_nx : r_freq[w_sel_nx];
    end
  end

  always_comb begin
    frequency_out = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      frequency_out[i*W +: W] = r_freq[i];
    end
  end

  assign sel_freq     = r_sel_freq;
  assign sel_chan     = r_sel;
  assign scale_out    = r_scale;
  assign update_pulse = r_upd;

endmodule
